// File: rtl/memory_bus_arbiter.sv
// Two-master arbiter for the shared core memory bus. Master 0 is the core memory port,
// master 1 the DMA/debug loader. Grants are registered and held for a whole transaction;
// the payload is passed through combinationally. A per-transaction watchdog aborts
// transactions that never see bus_ready.
// Optional feature: define ARBITER_ROUND_ROBIN_EN for round-robin resolution of
// simultaneous requests. Without it, master 0 always wins.
module memory_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_write_data,
    input  logic [3:0]  i_m0_byte_enable,
    input  logic        i_m0_read_enable,
    input  logic        i_m0_write_enable,
    output logic [31:0] o_m0_read_data,
    output logic        o_m0_ready,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_write_data,
    input  logic [3:0]  i_m1_byte_enable,
    input  logic        i_m1_read_enable,
    input  logic        i_m1_write_enable,
    output logic [31:0] o_m1_read_data,
    output logic        o_m1_ready,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_write_data,
    output logic [3:0]  o_bus_byte_enable,
    output logic        o_bus_read_enable,
    output logic        o_bus_write_enable,
    input  logic [31:0] i_bus_read_data,
    input  logic        i_bus_ready,
    output logic [1:0]  o_grant,
    output logic        o_bus_timeout
);

    typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

    // A zero TIMEOUT_CYCLES disables the watchdog entirely.
    localparam bit WdogEn = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLast =
        TIMEOUT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e                   r_state;
    logic [1:0]               r_grant;
    logic                     r_last_owner;
    logic [TIMEOUT_WIDTH-1:0] r_count;

    logic w_m0_req;
    logic w_m1_req;
    logic w_owner_req;
    logic w_timeout;
    logic w_pick_m1;

    assign w_m0_req = i_m0_read_enable | i_m0_write_enable;
    assign w_m1_req = i_m1_read_enable | i_m1_write_enable;

    // Request line of the current owner; 0 when idle.
    always_comb begin
        w_owner_req = 1'b0;
        case (r_state)
            StBusy0: w_owner_req = w_m0_req;
            StBusy1: w_owner_req = w_m1_req;
            default: w_owner_req = 1'b0;
        endcase
    end

    // Abort only a still-requesting owner; bus_ready in the same cycle wins.
    assign w_timeout = WdogEn && (r_state != StIdle) && w_owner_req && !i_bus_ready &&
                       (r_count == TimeoutLast);

    // Contention resolution while idle.
`ifdef ARBITER_ROUND_ROBIN_EN
    assign w_pick_m1 = w_m1_req && (!w_m0_req || (r_last_owner == 1'b0));
`else
    assign w_pick_m1 = w_m1_req && !w_m0_req;
`endif

    // State, grant, fairness history and watchdog counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_grant      <= 2'b00;
            r_last_owner <= 1'b1;
            r_count      <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_count <= '0;
                    if (w_pick_m1) begin
                        r_state <= StBusy1;
                        r_grant <= 2'b10;
                    end else if (w_m0_req) begin
                        r_state <= StBusy0;
                        r_grant <= 2'b01;
                    end
                end
                StBusy0, StBusy1: begin
                    if (!w_owner_req) begin
                        // Owner walked away: abandon without a completion.
                        r_state <= StIdle;
                        r_grant <= 2'b00;
                    end else if (i_bus_ready || w_timeout) begin
                        r_state      <= StIdle;
                        r_grant      <= 2'b00;
                        r_last_owner <= (r_state == StBusy1);
                    end else begin
                        r_count <= r_count + TIMEOUT_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    // Payload pass-through and completion signalling for the owner only.
    always_comb begin
        o_bus_address      = '0;
        o_bus_write_data   = '0;
        o_bus_byte_enable  = '0;
        o_bus_read_enable  = 1'b0;
        o_bus_write_enable = 1'b0;
        o_m0_read_data     = '0;
        o_m1_read_data     = '0;
        o_m0_ready         = 1'b0;
        o_m1_ready         = 1'b0;
        case (r_state)
            StBusy0: begin
                o_bus_address      = i_m0_address;
                o_bus_write_data   = i_m0_write_data;
                o_bus_byte_enable  = i_m0_byte_enable;
                o_bus_read_enable  = i_m0_read_enable;
                o_bus_write_enable = i_m0_write_enable;
                o_m0_read_data     = w_timeout ? 32'h0 : i_bus_read_data;
                o_m0_ready         = w_owner_req & (i_bus_ready | w_timeout);
            end
            StBusy1: begin
                o_bus_address      = i_m1_address;
                o_bus_write_data   = i_m1_write_data;
                o_bus_byte_enable  = i_m1_byte_enable;
                o_bus_read_enable  = i_m1_read_enable;
                o_bus_write_enable = i_m1_write_enable;
                o_m1_read_data     = w_timeout ? 32'h0 : i_bus_read_data;
                o_m1_ready         = w_owner_req & (i_bus_ready | w_timeout);
            end
            default: begin
            end
        endcase
    end

    assign o_grant       = r_grant;
    assign o_bus_timeout = w_timeout;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter with a 4-cycle watchdog.
module tb_memory_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
    logic [3:0]  m0_byte_enable, m1_byte_enable;
    logic        m0_read_enable, m0_write_enable, m1_read_enable, m1_write_enable;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_ready, m1_ready;
    logic [31:0] bus_address, bus_write_data, bus_read_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable, bus_write_enable, bus_ready;
    logic [1:0]  grant;
    logic        bus_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    memory_bus_arbiter #(
        .TIMEOUT_CYCLES(4),
        .TIMEOUT_WIDTH (3)
    ) u_dut (
        .i_clock           (clock),
        .i_reset           (reset),
        .i_m0_address      (m0_address),
        .i_m0_write_data   (m0_write_data),
        .i_m0_byte_enable  (m0_byte_enable),
        .i_m0_read_enable  (m0_read_enable),
        .i_m0_write_enable (m0_write_enable),
        .o_m0_read_data    (m0_read_data),
        .o_m0_ready        (m0_ready),
        .i_m1_address      (m1_address),
        .i_m1_write_data   (m1_write_data),
        .i_m1_byte_enable  (m1_byte_enable),
        .i_m1_read_enable  (m1_read_enable),
        .i_m1_write_enable (m1_write_enable),
        .o_m1_read_data    (m1_read_data),
        .o_m1_ready        (m1_ready),
        .o_bus_address     (bus_address),
        .o_bus_write_data  (bus_write_data),
        .o_bus_byte_enable (bus_byte_enable),
        .o_bus_read_enable (bus_read_enable),
        .o_bus_write_enable(bus_write_enable),
        .i_bus_read_data   (bus_read_data),
        .i_bus_ready       (bus_ready),
        .o_grant           (grant),
        .o_bus_timeout     (bus_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic settle();
        @(negedge clock);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " grant"}, {30'h0, grant}, 32'h0);
        check_eq({tag, " strobes"}, {30'h0, bus_read_enable, bus_write_enable}, 32'h0);
        check_eq({tag, " addr"}, bus_address, 32'h0);
        check_eq({tag, " readies"}, {30'h0, m0_ready, m1_ready}, 32'h0);
        check_eq({tag, " timeout"}, {31'h0, bus_timeout}, 32'h0);
    endtask

    initial begin
        logic [1:0] exp_grant [2];
`ifdef ARBITER_ROUND_ROBIN_EN
        exp_grant[0] = 2'b01;
        exp_grant[1] = 2'b10;
`else
        exp_grant[0] = 2'b01;
        exp_grant[1] = 2'b01;
`endif
        reset = 1'b1;
        m0_address = 32'h0; m0_write_data = 32'h0; m0_byte_enable = 4'h0;
        m0_read_enable = 1'b0; m0_write_enable = 1'b0;
        m1_address = 32'h0; m1_write_data = 32'h0; m1_byte_enable = 4'h0;
        m1_read_enable = 1'b0; m1_write_enable = 1'b0;
        bus_read_data = 32'h0; bus_ready = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        check_idle("reset");
        check_eq("reset m0_rdata", m0_read_data, 32'h0);
        next_cycle();
        reset = 1'b0;

        // Contention right after reset; m0 keeps re-requesting.
        m0_address = 32'h200; m0_read_enable = 1'b1; m0_byte_enable = 4'hF;
        m1_address = 32'h300; m1_write_enable = 1'b1; m1_write_data = 32'hA5A5A5A5;
        m1_byte_enable = 4'h3;
        settle();
        check_idle("cont req");
        for (int r = 0; r < 2; r++) begin
            next_cycle();
            bus_ready = 1'b1; bus_read_data = 32'h11110000;
            settle();
            check_eq($sformatf("cont%0d grant", r), {30'h0, grant}, {30'h0, exp_grant[r]});
            if (exp_grant[r] == 2'b01) begin
                check_eq($sformatf("cont%0d addr", r), bus_address, 32'h200);
                check_eq($sformatf("cont%0d ready", r), {30'h0, m0_ready, m1_ready}, 32'h2);
            end else begin
                check_eq($sformatf("cont%0d addr", r), bus_address, 32'h300);
                check_eq($sformatf("cont%0d wdata", r), bus_write_data, 32'hA5A5A5A5);
                check_eq($sformatf("cont%0d ready", r), {30'h0, m0_ready, m1_ready}, 32'h1);
            end
            next_cycle();
            bus_ready = 1'b0;
            settle();
            check_idle($sformatf("cont%0d gap", r));
        end
        m0_read_enable = 1'b0; m1_write_enable = 1'b0;
        next_cycle();

        // Single m0 read answered in the first BUSY cycle.
        m0_address = 32'h100; m0_read_enable = 1'b1;
        next_cycle();
        bus_ready = 1'b1; bus_read_data = 32'hDEADBEEF;
        settle();
        check_eq("rd strobe", {31'h0, bus_read_enable}, 32'h1);
        check_eq("rd addr", bus_address, 32'h100);
        check_eq("rd grant", {30'h0, grant}, 32'h1);
        check_eq("rd m0_ready", {31'h0, m0_ready}, 32'h1);
        check_eq("rd m0_rdata", m0_read_data, 32'hDEADBEEF);
        check_eq("rd m1_ready", {31'h0, m1_ready}, 32'h0);
        check_eq("rd m1_rdata", m1_read_data, 32'h0);
        next_cycle();
        m0_read_enable = 1'b0; bus_ready = 1'b0;
        settle();
        check_idle("rd done");
        next_cycle();

        // m1 write with bus_ready arriving in the third BUSY cycle.
        m1_address = 32'h400; m1_write_data = 32'h12345678; m1_byte_enable = 4'hF;
        m1_write_enable = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            bus_ready = (c == 3);
            settle();
            check_eq($sformatf("ws%0d we", c), {31'h0, bus_write_enable}, 32'h1);
            check_eq($sformatf("ws%0d data", c), bus_write_data, 32'h12345678);
            check_eq($sformatf("ws%0d be", c), {28'h0, bus_byte_enable}, 32'hF);
            check_eq($sformatf("ws%0d grant", c), {30'h0, grant}, 32'h2);
            check_eq($sformatf("ws%0d m1_ready", c), {31'h0, m1_ready}, (c == 3) ? 32'h1 : 32'h0);
        end
        next_cycle();
        m1_write_enable = 1'b0; bus_ready = 1'b0;
        settle();
        check_idle("ws done");
        next_cycle();

        // Watchdog: bus_ready never comes, abort in the fourth BUSY cycle.
        m0_address = 32'h500; m0_read_enable = 1'b1; bus_read_data = 32'hCAFEF00D;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            settle();
            check_eq($sformatf("to%0d grant", c), {30'h0, grant}, 32'h1);
            check_eq($sformatf("to%0d timeout", c), {31'h0, bus_timeout}, (c == 4) ? 32'h1 : 32'h0);
            check_eq($sformatf("to%0d m0_ready", c), {31'h0, m0_ready}, (c == 4) ? 32'h1 : 32'h0);
            check_eq($sformatf("to%0d m0_rdata", c), m0_read_data,
                     (c == 4) ? 32'h0 : 32'hCAFEF00D);
        end
        next_cycle();
        m0_read_enable = 1'b0;
        settle();
        check_idle("to done");
        next_cycle();

        // Reset while m1 owns the bus, then contention goes to m0.
        m1_address = 32'h600; m1_read_enable = 1'b1;
        next_cycle();
        settle();
        check_eq("rst busy grant", {30'h0, grant}, 32'h2);
        check_eq("rst busy m1_ready", {31'h0, m1_ready}, 32'h0);
        next_cycle();
        reset = 1'b1;
        settle();
        check_eq("rst asserted m1_ready", {31'h0, m1_ready}, 32'h0);
        next_cycle();
        reset = 1'b0;
        m0_address = 32'h700; m0_read_enable = 1'b1;
        settle();
        check_idle("rst after");
        next_cycle();
        bus_ready = 1'b1; bus_read_data = 32'h0BADF00D;
        settle();
        check_eq("rst cont grant", {30'h0, grant}, 32'h1);
        check_eq("rst cont addr", bus_address, 32'h700);
        check_eq("rst cont ready", {30'h0, m0_ready, m1_ready}, 32'h2);
        next_cycle();
        m0_read_enable = 1'b0; m1_read_enable = 1'b0; bus_ready = 1'b0;
        settle();
        check_idle("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Two-master arbiter that shares the single core memory bus between master 0 (core memory port) and master 1 (DMA/debug loader).
- Sits between the requesters and the bus, on the same bus that the data memory interface drives.
- Adds a bus_ready wait-state handshake and a per-transaction timeout watchdog.
- Grants are registered and held until the transaction completes or times out.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUSY without bus_ready before forced abort. 0 disables the watchdog.
- TIMEOUT_WIDTH, 8: width of the watchdog counter. Must satisfy 2**TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clock  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high
- m0_address  input  32  master 0 byte address
- m0_write_data  input  32  master 0 store data
- m0_byte_enable  input  4  master 0 byte lanes
- m0_read_enable  input  1  master 0 read request
- m0_write_enable  input  1  master 0 write request
- m0_read_data  output  32  master 0 load data
- m0_ready  output  1  master 0 completion pulse
- m1_*  (same seven signals as m0_*)  master 1
- bus_address  output  32  shared bus address
- bus_write_data  output  32  shared bus store data
- bus_byte_enable  output  4  shared bus byte lanes
- bus_read_enable  output  1  shared bus read strobe
- bus_write_enable  output  1  shared bus write strobe
- bus_read_data  input  32  shared bus load data
- bus_ready  input  1  slave completion, same cycle as valid read data
- grant  output  2  one-hot current owner; 00 when idle
- bus_timeout  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Request: mN_req = mN_read_enable | mN_write_enable.
  - Master must hold the request and all payload stable until its mN_ready.
  - Asserting both read and write enables together is illegal; the payload is forwarded unchanged.
- States: IDLE, BUSY0, BUSY1. Reset forces IDLE, clears the watchdog counter and sets last_owner=1.
- Reset values and IDLE outputs: all bus_* outputs 0, grant=00, m0_ready=m1_ready=0, bus_timeout=0. mN_read_data=0 whenever master N is not the owner.
- IDLE transitions:
  - m0_req only -> BUSY0.
  - m1_req only -> BUSY1.
  - Both requesting -> decided by priority rule (see Optional Feature).
  - Neither -> stay in IDLE.
- BUSYn outputs: bus_* = master n payload (combinational pass-through); grant one-hot n; mn_read_data = bus_read_data.
- BUSYn completion: mn_ready = bus_ready. On bus_ready, go to IDLE next cycle and set last_owner=n.
- Latency: request seen at edge t, bus strobes asserted in cycle t+1. Minimum turnaround is 2 cycles per transaction (including the mandatory IDLE cycle).
- Back-to-back: always one IDLE cycle between transactions. No grant may change while in BUSY.
- Owner withdraws request before bus_ready (protocol violation):
  - Bus strobes follow the dropped enables, i.e. fall immediately.
  - Arbiter returns to IDLE next cycle; mn_ready stays 0.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle without bus_ready.
  - When count == TIMEOUT_CYCLES-1 and bus_ready is still 0: mn_ready=1, mn_read_data=0, bus_timeout=1 for that cycle, then IDLE.
  - bus_ready in the same cycle takes precedence: normal completion, no timeout.
- Reset mid-transaction: next cycle is IDLE with all strobes 0. The in-flight transaction is abandoned and no ready is issued.
- Non-owner always sees mN_ready=0, even if bus_ready is asserted.

Optional Feature:
- Macro: ARBITER_ROUND_ROBIN_EN.
- Defined: simultaneous requests in IDLE go to the master that is not last_owner. last_owner updates on every completion, including timeouts.
- Undefined: fixed priority, m0 always wins. last_owner is still maintained but unused.

Test Plan:
- Single m0 read: m0_read_enable=1, address 0x100; bus_ready=1 in the first BUSY cycle with bus_read_data 0xDEADBEEF.
  -> bus_read_enable=1 and bus_address=0x100 at t+1; m0_ready=1 and m0_read_data=0xDEADBEEF in that cycle; grant=01; IDLE at t+2.
- Contention: both masters request at t.
  -> Round-robin build: m0 then m1, grants 01 then 10, with one IDLE cycle between.
  -> Fixed build with m0 re-requesting every time: m1 starved, grant=01 each time.
- Wait states: m1 write of 0x12345678, byte_enable 0xF; bus_ready delayed 3 cycles.
  -> bus_write_enable held 3 cycles with a stable payload; m1_ready=1 only in the 3rd BUSY cycle.
- Timeout: TIMEOUT_CYCLES=4, bus_ready tied 0.
  -> After 4 BUSY cycles: m0_ready=1, m0_read_data=0, bus_timeout=1 for exactly 1 cycle; then IDLE with strobes 0.
- Reset mid-BUSY: reset asserted while in BUSY1.
  -> Next cycle: grant=00, all bus_* 0, m1_ready never asserted. The first contention after reset is won by m0.
